// File: rtl/hilo_mult_ctrl.sv
// rtl/hilo_mult_ctrl.sv - HI/LO owner and sequencer for the iterative multiplier
// Holds EX on HI/LO hazards, drives Work/Done handshake, flush-abort and timeout watchdog.
module hilo_mult_ctrl #(
  parameter int NBit    = 32,
  parameter int TIMEOUT = 40
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Op_valid,
  input  logic [2:0]        Op_code,
  input  logic [NBit-1:0]   Op_a,
  input  logic [NBit-1:0]   Op_b,
  input  logic              Flush,
  output logic              Stall,
  output logic [NBit-1:0]   Rd_data,
  output logic              Busy,
  output logic              Err,
  output logic [NBit-1:0]   Mul_a,
  output logic [NBit-1:0]   Mul_b,
  output logic              Mul_sign,
  output logic              Mul_work,
  input  logic              Mul_done,
  input  logic [2*NBit-1:0] Mul_result
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [NBit-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [NBit-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic            mul_sign_q, mul_sign_d;
  logic            mul_work_q, mul_work_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic is_mul, is_hilo, accept;

  assign is_mul  = (Op_code == 3'd1) || (Op_code == 3'd2);
  assign is_hilo = (Op_code >= 3'd3) && (Op_code <= 3'd6);

  // MULT waits for full idle; HI/LO ops only wait while the product is outstanding
  assign Stall = Op_valid && !Flush &&
                 ((is_mul && state_q != S_IDLE) || (is_hilo && state_q == S_BUSY));
  assign accept = Op_valid && !Stall && !Flush && (is_mul || is_hilo);

  assign Rd_data  = (accept && Op_code == 3'd5) ? hi_q :
                    (accept && Op_code == 3'd6) ? lo_q : '0;
  assign Busy     = (state_q != S_IDLE);
  assign Err      = err_q;
  assign Mul_a    = mul_a_q;
  assign Mul_b    = mul_b_q;
  assign Mul_sign = mul_sign_q;
  assign Mul_work = mul_work_q;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_sign_d = mul_sign_q;
    mul_work_d = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          mul_a_d    = Op_a;
          mul_b_d    = Op_b;
          mul_sign_d = (Op_code == 3'd1);
          cnt_d      = '0;
          mul_work_d = 1'b1;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d      = cnt_q + CW'(1);
        mul_work_d = 1'b1;
        // A Done in the flush cycle still commits: the multiply already retired
        if (Mul_done) begin
          {hi_d, lo_d} = Mul_result;
          mul_work_d   = 1'b0;
          state_d      = S_DRAIN;
        end else if (Flush) begin
          mul_work_d = 1'b0;
          state_d    = S_DRAIN;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          mul_work_d = 1'b0;
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept && Op_code == 3'd3) hi_d = Op_a;
    if (accept && Op_code == 3'd4) lo_d = Op_a;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_sign_q <= 1'b0;
      mul_work_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_sign_q <= mul_sign_d;
      mul_work_q <= mul_work_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// tb/tb_hilo_mult_ctrl.sv - bench for hilo_mult_ctrl
// Vector table for idle HI/LO traffic, randomized multiplies against an arithmetic model, corner sequences.
module tb_hilo_mult_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Op_valid;
  logic [2:0]  Op_code;
  logic [31:0] Op_a, Op_b;
  logic        Flush;
  logic        Stall;
  logic [31:0] Rd_data;
  logic        Busy, Err;
  logic [31:0] Mul_a, Mul_b;
  logic        Mul_sign, Mul_work;
  logic        Mul_done;
  logic [63:0] Mul_result;

  int   checks = 0;
  int   errors = 0;
  int   wcnt = 0;
  logic mdone = 1'b0;
  logic done_en = 1'b1;
  logic done_force = 1'b0;
  logic [31:0] hi_m, lo_m;

  hilo_mult_ctrl #(.NBit(32), .TIMEOUT(40)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Op_valid(Op_valid), .Op_code(Op_code),
    .Op_a(Op_a), .Op_b(Op_b), .Flush(Flush), .Stall(Stall), .Rd_data(Rd_data),
    .Busy(Busy), .Err(Err), .Mul_a(Mul_a), .Mul_b(Mul_b), .Mul_sign(Mul_sign),
    .Mul_work(Mul_work), .Mul_done(Mul_done), .Mul_result(Mul_result)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Multiplier model: Done after 33 consecutive Work cycles, cleared when Work drops
  always @(negedge Clk) begin
    if (Mul_work) wcnt = wcnt + 1;
    else          wcnt = 0;
    mdone = done_en && Mul_work && (wcnt >= 33);
  end
  assign Mul_done   = mdone | done_force;
  assign Mul_result = prod(Mul_sign, Mul_a, Mul_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] code, input logic [31:0] a,
                     input logic [31:0] b, input logic fl);
    Op_valid = v; Op_code = code; Op_a = a; Op_b = b; Flush = fl;
  endtask

  // Starts in the current cycle T; returns in T+35 with the follow-up op still driven if it is a multiply
  task automatic do_mult(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] nxt, input logic [31:0] nd);
    logic [63:0] p;
    logic        nv;
    p  = prod(code == 3'd1, a, b);
    nv = (nxt != 3'd0);
    drv(1'b1, code, a, b, 1'b0); #1;
    chk("mul_accept_stall", 64'(Stall), 64'd0);
    chk("mul_accept_busy", 64'(Busy), 64'd0);
    @(negedge Clk);
    for (int k = 1; k <= 33; k++) begin
      drv(nv, nxt, nd, nd, 1'b0); #1;
      chk("busy_work", 64'({Busy, Mul_work}), 64'd3);
      chk("busy_mul_a", 64'(Mul_a), 64'(a));
      chk("busy_mul_b", 64'(Mul_b), 64'(b));
      chk("busy_mul_sign", 64'(Mul_sign), 64'(code == 3'd1));
      if (nv) chk("busy_stall", 64'(Stall), 64'd1);
      @(negedge Clk);
    end
    drv(nv, nxt, nd, nd, 1'b0); #1;
    chk("drain_state", 64'({Busy, Mul_work}), 64'd2);
    hi_m = p[63:32];
    lo_m = p[31:0];
    if (nv) chk("drain_stall", 64'(Stall), 64'(nxt == 3'd1 || nxt == 3'd2));
    if (nxt == 3'd5) chk("drain_mfhi", 64'(Rd_data), 64'(hi_m));
    if (nxt == 3'd6) chk("drain_mflo", 64'(Rd_data), 64'(lo_m));
    if (nxt == 3'd3) hi_m = nd;
    if (nxt == 3'd4) lo_m = nd;
    @(negedge Clk);
    if (nxt == 3'd1 || nxt == 3'd2) drv(1'b1, nxt, nd, nd, 1'b0);
    else                            drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    #1;
    chk("idle_after_mult", 64'(Busy), 64'd0);
    if (nxt == 3'd1 || nxt == 3'd2) chk("b2b_accept_stall", 64'(Stall), 64'd0);
  endtask

  task automatic read_hilo(input string name);
    drv(1'b1, 3'd5, 32'd0, 32'd0, 1'b0); #1;
    chk({name, "_hi"}, 64'(Rd_data), 64'(hi_m));
    @(negedge Clk);
    drv(1'b1, 3'd6, 32'd0, 32'd0, 1'b0); #1;
    chk({name, "_lo"}, 64'(Rd_data), 64'(lo_m));
    @(negedge Clk);
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    drv(1'b1, 3'd3, h, 32'd0, 1'b0); #1; @(negedge Clk);
    drv(1'b1, 3'd4, l, 32'd0, 1'b0); #1; @(negedge Clk);
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    hi_m = h; lo_m = l;
  endtask

  typedef struct {
    logic        v;
    logic        fl;
    logic [2:0]  code;
    logic [31:0] a;
    logic        exp_stall;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'd3, 32'h11111111, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 3'd4, 32'h22222222, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 3'd5, 32'h0,        1'b0, 32'h11111111};
    tbl[3]  = '{1'b1, 1'b0, 3'd6, 32'h0,        1'b0, 32'h22222222};
    tbl[4]  = '{1'b1, 1'b1, 3'd5, 32'h0,        1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 3'd3, 32'h33333333, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 3'd5, 32'h0,        1'b0, 32'h11111111};
    tbl[7]  = '{1'b1, 1'b0, 3'd7, 32'h44444444, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 3'd5, 32'h0,        1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 3'd0, 32'h55555555, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 3'd4, 32'h66666666, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 3'd6, 32'h0,        1'b0, 32'h22222222};

    Reset_n = 1'b0;
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    #1;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_work", 64'(Mul_work), 64'd0);
    chk("rst_err", 64'(Err), 64'd0);
    chk("rst_mul_a", 64'(Mul_a), 64'd0);
    chk("rst_mul_sign", 64'(Mul_sign), 64'd0);
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    read_hilo("rst_hilo");

    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].v, tbl[i].code, tbl[i].a, 32'd0, tbl[i].fl); #1;
      chk($sformatf("tbl%0d_stall", i), 64'(Stall), 64'(tbl[i].exp_stall));
      chk($sformatf("tbl%0d_rd", i), 64'(Rd_data), 64'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_busy", i), 64'(Busy), 64'd0);
      @(negedge Clk);
    end
    hi_m = 32'h11111111; lo_m = 32'h22222222;

    // Signed product and MULTU followed by a hazarding MFHI
    do_mult(3'd1, 32'hFFFFFFFE, 32'h00000003, 3'd0, 32'd0);
    chk("t2_hi", 64'(hi_m), 64'hFFFFFFFF);
    read_hilo("t2");
    do_mult(3'd2, 32'hFFFFFFFF, 32'h00000002, 3'd5, 32'd0);
    chk("t3_hi", 64'(hi_m), 64'h00000001);
    read_hilo("t3");

    // Done outside BUSY must not touch HI/LO
    write_hilo(32'hDEADBEEF, 32'hCAFEF00D);
    done_force = 1'b1;
    @(negedge Clk); @(negedge Clk); #1;
    chk("stray_done_busy", 64'(Busy), 64'd0);
    done_force = 1'b0;
    read_hilo("stray_done");

    // Back-to-back multiplies
    do_mult(3'd1, 32'h00001234, 32'hFFFF0000, 3'd2, 32'h89ABCDEF);
    do_mult(3'd2, 32'h89ABCDEF, 32'h89ABCDEF, 3'd6, 32'd0);
    read_hilo("b2b");

    for (int r = 0; r < 12; r++) begin
      logic [2:0]  c, n;
      logic [31:0] a, b;
      c = 3'($urandom_range(1, 2));
      a = (r % 4 == 0) ? 32'h80000000 : $urandom;
      b = (r % 4 == 1) ? 32'hFFFFFFFF : $urandom;
      case ($urandom_range(0, 4))
        0: n = 3'd0; 1: n = 3'd3; 2: n = 3'd4; 3: n = 3'd5; default: n = 3'd6;
      endcase
      do_mult(c, a, b, n, $urandom);
    end
    read_hilo("rand");

    // Flush at T+10 leaves HI/LO untouched
    write_hilo(32'h12345678, 32'h12345678);
    drv(1'b1, 3'd1, 32'd5, 32'd7, 1'b0); #1; @(negedge Clk);
    for (int k = 1; k <= 9; k++) begin
      drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0); #1;
      chk("flush_busy", 64'({Busy, Mul_work}), 64'd3);
      @(negedge Clk);
    end
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b1); #1;
    chk("flush_cycle_busy", 64'(Busy), 64'd1);
    @(negedge Clk);
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0); #1;
    chk("flush_drain", 64'({Busy, Mul_work}), 64'd2);
    @(negedge Clk); #1;
    chk("flush_idle", 64'(Busy), 64'd0);
    read_hilo("flush");

    // Done never arrives: watchdog fires after TIMEOUT busy cycles
    done_en = 1'b0;
    drv(1'b1, 3'd2, 32'd9, 32'd9, 1'b0); #1; @(negedge Clk);
    for (int k = 1; k <= 40; k++) begin
      drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0); #1;
      chk("to_busy", 64'({Busy, Mul_work}), 64'd3);
      chk("to_err_low", 64'(Err), 64'd0);
      @(negedge Clk);
    end
    #1;
    chk("to_drain", 64'({Busy, Mul_work}), 64'd2);
    chk("to_err_set", 64'(Err), 64'd1);
    @(negedge Clk); #1;
    chk("to_idle", 64'(Busy), 64'd0);
    done_en = 1'b1;
    drv(1'b1, 3'd4, 32'hA5A5A5A5, 32'd0, 1'b0); #1; @(negedge Clk);
    drv(1'b1, 3'd6, 32'd0, 32'd0, 1'b0); #1;
    chk("to_mflo", 64'(Rd_data), 64'hA5A5A5A5);
    chk("to_err_sticky", 64'(Err), 64'd1);
    @(negedge Clk);

    // Asynchronous reset in the middle of a multiply
    write_hilo(32'h77777777, 32'h88888888);
    drv(1'b1, 3'd1, 32'd3, 32'd4, 1'b0); #1; @(negedge Clk);
    drv(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_work", 64'(Mul_work), 64'd0);
    chk("midrst_err", 64'(Err), 64'd0);
    chk("midrst_mul_a", 64'(Mul_a), 64'd0);
    chk("midrst_mul_b", 64'(Mul_b), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    read_hilo("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
